// File: rtl/sys_defs.sv
//------------------------------------------------------------------------------
// Module   : sys_defs
// Brief    : Shared types and constants for the RV32IM decode stage.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sys_defs;

   localparam int ARF_W = 5;
   localparam int PC_W  = 32;

   localparam logic [ARF_W-1:0] ZERO_REG = '0;
   localparam logic             TRUE     = 1'b1;
   localparam logic             FALSE    = 1'b0;

   localparam logic [6:0] RV32_LUI    = 7'b0110111;
   localparam logic [6:0] RV32_AUIPC  = 7'b0010111;
   localparam logic [6:0] RV32_JAL    = 7'b1101111;
   localparam logic [6:0] RV32_JALR   = 7'b1100111;
   localparam logic [6:0] RV32_BRANCH = 7'b1100011;
   localparam logic [6:0] RV32_LOAD   = 7'b0000011;
   localparam logic [6:0] RV32_STORE  = 7'b0100011;
   localparam logic [6:0] RV32_OPIMM  = 7'b0010011;
   localparam logic [6:0] RV32_OP     = 7'b0110011;
   localparam logic [6:0] RV32_FENCE  = 7'b0001111;
   localparam logic [6:0] RV32_SYSTEM = 7'b1110011;
   localparam logic [31:0] RV32_WFI   = 32'h1050_0073;

   typedef enum logic [1:0] {
      OPA_IS_RS1, OPA_IS_NPC, OPA_IS_PC, OPA_IS_ZERO
   } ALU_OPA_SELECT;

   typedef enum logic [2:0] {
      OPB_IS_RS2, OPB_IS_I_IMM, OPB_IS_S_IMM, OPB_IS_B_IMM, OPB_IS_U_IMM, OPB_IS_J_IMM
   } ALU_OPB_SELECT;

   typedef enum logic [0:0] {
      DEST_NONE, DEST_RD
   } DEST_REG_SEL;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
      ALU_SRL, ALU_SRA, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV,
      ALU_DIVU, ALU_REM, ALU_REMU
   } ALU_FUNC;

   typedef struct packed {
      logic [PC_W-1:0]  pc;
      logic [31:0]      inst;
      logic [ARF_W-1:0] op1_arn;
      logic [ARF_W-1:0] op2_arn;
      logic [ARF_W-1:0] dest_arn;
      logic             use_opa_arn;
      logic             use_opb_arn;
      ALU_OPA_SELECT    opa_select;
      ALU_OPB_SELECT    opb_select;
      DEST_REG_SEL      dest_select;
      ALU_FUNC          alu_func;
      logic             rd_mem;
      logic             wr_mem;
      logic             cond_branch;
      logic             uncond_branch;
      logic             csr_op;
      logic             halt;
      logic             illegal;
   } ID_PACKET;

endpackage

`default_nettype wire

// File: rtl/decode_lane.sv
//------------------------------------------------------------------------------
// Module   : decode_lane
// Brief    : Combinational single-instruction RV32IM decoder (pc left zero).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module decode_lane
   import sys_defs::*;
(
   input  logic [31:0] i_inst,
   input  logic        i_valid,
   output ID_PACKET    o_pkt
);

   logic [6:0] w_opc;
   logic [2:0] w_f3;
   logic [6:0] w_f7;

   assign w_opc = i_inst[6:0];
   assign w_f3  = i_inst[14:12];
   assign w_f7  = i_inst[31:25];

   always_comb begin
      o_pkt = '0;
      if (i_valid) begin
         o_pkt.inst        = i_inst;
         o_pkt.op1_arn     = i_inst[19:15];
         o_pkt.op2_arn     = i_inst[24:20];
         o_pkt.opa_select  = OPA_IS_RS1;
         o_pkt.opb_select  = OPB_IS_RS2;
         o_pkt.dest_select = DEST_NONE;
         o_pkt.alu_func    = ALU_ADD;
         o_pkt.illegal     = FALSE;
         case (w_opc)
            RV32_LUI: begin
               o_pkt.opa_select = OPA_IS_ZERO; o_pkt.opb_select = OPB_IS_U_IMM; o_pkt.dest_select = DEST_RD;
            end
            RV32_AUIPC: begin
               o_pkt.opa_select = OPA_IS_PC; o_pkt.opb_select = OPB_IS_U_IMM; o_pkt.dest_select = DEST_RD;
            end
            RV32_JAL: begin
               o_pkt.opa_select = OPA_IS_PC; o_pkt.opb_select = OPB_IS_J_IMM;
               o_pkt.dest_select = DEST_RD; o_pkt.uncond_branch = TRUE;
            end
            RV32_JALR: begin
               o_pkt.opb_select = OPB_IS_I_IMM; o_pkt.dest_select = DEST_RD;
               o_pkt.uncond_branch = TRUE; o_pkt.illegal = (w_f3 != 3'd0);
            end
            RV32_BRANCH: begin
               o_pkt.opa_select = OPA_IS_PC; o_pkt.opb_select = OPB_IS_B_IMM;
               o_pkt.illegal = (w_f3 == 3'd2) || (w_f3 == 3'd3);
               o_pkt.cond_branch = ~o_pkt.illegal;
            end
            RV32_LOAD: begin
               o_pkt.opb_select = OPB_IS_I_IMM; o_pkt.dest_select = DEST_RD; o_pkt.rd_mem = TRUE;
               o_pkt.illegal = (w_f3 == 3'd3) || (w_f3 > 3'd5);
            end
            RV32_STORE: begin
               o_pkt.opb_select = OPB_IS_S_IMM; o_pkt.wr_mem = TRUE; o_pkt.illegal = (w_f3 > 3'd2);
            end
            RV32_OPIMM: begin
               o_pkt.opb_select = OPB_IS_I_IMM; o_pkt.dest_select = DEST_RD;
               case (w_f3)
                  3'd0: o_pkt.alu_func = ALU_ADD;
                  3'd1: begin o_pkt.alu_func = ALU_SLL; o_pkt.illegal = (w_f7 != 7'h00); end
                  3'd2: o_pkt.alu_func = ALU_SLT;
                  3'd3: o_pkt.alu_func = ALU_SLTU;
                  3'd4: o_pkt.alu_func = ALU_XOR;
                  3'd5: begin
                     o_pkt.alu_func = (w_f7 == 7'h20) ? ALU_SRA : ALU_SRL;
                     o_pkt.illegal  = (w_f7 != 7'h00) && (w_f7 != 7'h20);
                  end
                  3'd6: o_pkt.alu_func = ALU_OR;
                  default: o_pkt.alu_func = ALU_AND;
               endcase
            end
            RV32_OP: begin
               o_pkt.dest_select = DEST_RD;
               case ({w_f7, w_f3})
                  {7'h00, 3'd0}: o_pkt.alu_func = ALU_ADD;
                  {7'h20, 3'd0}: o_pkt.alu_func = ALU_SUB;
                  {7'h00, 3'd1}: o_pkt.alu_func = ALU_SLL;
                  {7'h00, 3'd2}: o_pkt.alu_func = ALU_SLT;
                  {7'h00, 3'd3}: o_pkt.alu_func = ALU_SLTU;
                  {7'h00, 3'd4}: o_pkt.alu_func = ALU_XOR;
                  {7'h00, 3'd5}: o_pkt.alu_func = ALU_SRL;
                  {7'h20, 3'd5}: o_pkt.alu_func = ALU_SRA;
                  {7'h00, 3'd6}: o_pkt.alu_func = ALU_OR;
                  {7'h00, 3'd7}: o_pkt.alu_func = ALU_AND;
                  {7'h01, 3'd0}: o_pkt.alu_func = ALU_MUL;
                  {7'h01, 3'd1}: o_pkt.alu_func = ALU_MULH;
                  {7'h01, 3'd2}: o_pkt.alu_func = ALU_MULHSU;
                  {7'h01, 3'd3}: o_pkt.alu_func = ALU_MULHU;
                  {7'h01, 3'd4}: o_pkt.alu_func = ALU_DIV;
                  {7'h01, 3'd5}: o_pkt.alu_func = ALU_DIVU;
                  {7'h01, 3'd6}: o_pkt.alu_func = ALU_REM;
                  {7'h01, 3'd7}: o_pkt.alu_func = ALU_REMU;
                  default:       o_pkt.illegal  = TRUE;
               endcase
            end
            RV32_FENCE: o_pkt.opa_select = OPA_IS_ZERO;
            RV32_SYSTEM: begin
               if (i_inst == RV32_WFI) begin
                  o_pkt.halt = TRUE;
               end else if ((w_f3 != 3'd0) && (w_f3 != 3'd4)) begin
                  // Immediate CSR forms (funct3[2]) take no register operand.
                  o_pkt.csr_op      = TRUE;
                  o_pkt.dest_select = DEST_RD;
                  o_pkt.opa_select  = w_f3[2] ? OPA_IS_ZERO : OPA_IS_RS1;
               end else begin
                  o_pkt.illegal = TRUE;
               end
            end
            default: o_pkt.illegal = TRUE;
         endcase
         o_pkt.dest_arn    = (o_pkt.dest_select == DEST_RD && !o_pkt.illegal) ? i_inst[11:7] : ZERO_REG;
         o_pkt.use_opa_arn = ((o_pkt.opa_select == OPA_IS_RS1) & ~o_pkt.illegal & ~o_pkt.halt)
                             | o_pkt.cond_branch;
         o_pkt.use_opb_arn = ((o_pkt.opb_select == OPB_IS_RS2) & ~o_pkt.illegal & ~o_pkt.halt)
                             | o_pkt.cond_branch | o_pkt.wr_mem;
      end
   end

endmodule

`default_nettype wire

// File: rtl/decode_stage_nway.sv
//------------------------------------------------------------------------------
// Module   : decode_stage_nway
// Brief    : N-way in-order decode stage: group formation + stallable register.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module decode_stage_nway
   import sys_defs::*;
#(
   parameter int WAY       = 3,
   parameter int ARF_WIDTH = 5,
   parameter int PC_WIDTH  = 32,
   parameter int CNT_WIDTH = $clog2(WAY + 1)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [WAY-1:0][31:0]          if_inst,
   input  logic [WAY-1:0][PC_WIDTH-1:0]  if_pc,
   input  logic [WAY-1:0]                if_valid,
   output logic [CNT_WIDTH-1:0]          if_accept_cnt,
   input  logic                          dp_stall,
   input  logic                          flush,
   output ID_PACKET [WAY-1:0]            id_packet,
   output logic [WAY-1:0]                id_valid,
   output logic                          id_halted,
   output logic [31:0]                   id_decoded_cnt
);

   ID_PACKET              w_lane [WAY];
   logic [WAY-1:0]        w_cut;
   logic [WAY-1:0]        w_take;
   logic [CNT_WIDTH-1:0]  w_accept;
   logic                  w_take_halt;
   logic                  w_load_en;
   logic                  w_form_en;

   ID_PACKET [WAY-1:0]    r_pkt;
   logic [WAY-1:0]        r_valid;
   logic                  r_halted;
   logic [31:0]           r_cnt;

   generate
      for (genvar gi = 0; gi < WAY; gi++) begin : g_lane
         decode_lane u_lane (
            .i_inst  (if_inst[gi]),
            .i_valid (if_valid[gi]),
            .o_pkt   (w_lane[gi])
         );
         if (gi == 0) begin : g_first
            assign w_cut[gi] = 1'b0;
         end else begin : g_rest
            // A CSR must sit alone; a halt or illegal lane closes the group.
            assign w_cut[gi] = w_lane[gi].csr_op | w_lane[gi-1].csr_op
                             | w_lane[gi-1].halt | w_lane[gi-1].illegal;
         end
      end
   endgenerate

   assign w_load_en = ~dp_stall | ~(|r_valid);
   assign w_form_en = w_load_en & ~r_halted & ~flush & ~reset;

   always_comb begin
      logic w_go;
      w_go        = w_form_en;
      w_take      = '0;
      w_accept    = '0;
      w_take_halt = 1'b0;
      for (int i = 0; i < WAY; i++) begin
         w_go      = w_go & if_valid[i] & ~w_cut[i];
         w_take[i] = w_go;
         if (w_go) begin
            w_accept    = w_accept + CNT_WIDTH'(1);
            w_take_halt = w_take_halt | w_lane[i].halt;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pkt    <= '0;
         r_valid  <= '0;
         r_halted <= 1'b0;
         r_cnt    <= '0;
      end else if (flush) begin
         r_pkt    <= '0;
         r_valid  <= '0;
         r_halted <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_cnt <= r_cnt + 32'(w_accept);
         if (w_load_en) begin
            for (int i = 0; i < WAY; i++) begin
               if (w_take[i]) begin
                  r_pkt[i]    <= w_lane[i];
                  r_pkt[i].pc <= if_pc[i];
               end else begin
                  r_pkt[i]    <= '0;
               end
            end
            r_valid <= w_take;
         end
         if (w_take_halt) begin
            r_halted <= 1'b1;
         end
      end
   end

   assign if_accept_cnt  = w_accept;
   assign id_packet      = r_pkt;
   assign id_valid       = r_valid;
   assign id_halted      = r_halted;
   assign id_decoded_cnt = r_cnt;

endmodule

`default_nettype wire
